// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues imem reads, buffers
// sequential words in a DEPTH-entry FIFO, and handles redirect, data stall and halt.
module fetch_unit #(
    parameter int                WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0,
    parameter int                DEPTH   = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       ihit,
    input  logic [WORD_W-1:0]          imemload,
    output logic                       imemREN,
    output logic [WORD_W-1:0]          imemaddr,
    input  logic                       dstall,
    input  logic                       redirect,
    input  logic [WORD_W-1:0]          redirect_pc,
    input  logic                       halt_in,
    output logic                       instr_valid,
    output logic [WORD_W-1:0]          instr,
    output logic [WORD_W-1:0]          instr_pc,
    input  logic                       instr_ready,
    output logic                       halt,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HALTED} state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_fpc;
    logic              r_halt;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [WORD_W-1:0] r_q_instr [DEPTH];
    logic [WORD_W-1:0] r_q_pc    [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_can_req;
    logic [CW-1:0]     w_cnt_next;
    logic [WORD_W-1:0] w_redir_pc;

    // Halt takes priority over both redirect and a completing fetch.
    assign w_push      = (r_state == S_REQ) && ihit && !redirect && !halt_in;
    assign w_pop       = instr_valid && instr_ready;
    assign w_flush     = (r_state != S_HALTED) && redirect && !halt_in;
    assign w_cnt_next  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_can_req   = !dstall && (w_cnt_next < DEPTH_C);
    assign w_redir_pc  = redirect_pc & ~WORD_W'(3);

    assign imemREN     = (r_state == S_REQ) && !redirect && !halt_in;
    assign imemaddr    = r_fpc;
    assign instr_valid = (r_count != '0) && !r_halt;
    assign instr       = r_q_instr[r_rptr];
    assign instr_pc    = r_q_pc[r_rptr];
    assign halt        = r_halt;
    assign count       = r_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_fpc   <= PC_INIT;
            r_halt  <= 1'b0;
        end else if (r_state != S_HALTED) begin
            if (halt_in) begin
                r_state <= S_HALTED;
                r_halt  <= 1'b1;
            end else if (redirect) begin
                r_fpc   <= w_redir_pc;
                r_state <= S_IDLE;
            end else if (r_state == S_REQ && !ihit) begin
                r_state <= S_REQ;
            end else begin
                if (w_push)
                    r_fpc <= r_fpc + WORD_W'(4);
                r_state <= w_can_req ? S_REQ : S_IDLE;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= w_cnt_next;
        end
    end

    // Queue storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_q_instr[r_wptr] <= imemload;
            r_q_pc[r_wptr]    <= r_fpc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a queue of expected {pc, instr} entries is
// filled as fetches are granted and drained as the consumer accepts heads.
module tb_fetch_unit;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dstall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt_in;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        halt;
    logic [2:0]  count;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb [$];

    fetch_unit #(.WORD_W(32), .PC_INIT(32'h0), .DEPTH(4)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .dstall(dstall),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt_in(halt_in),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .halt(halt), .count(count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Instruction memory model: answers whatever address is presented.
    assign imemload = mem_word(imemaddr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        ihit = 1'b1;
        #1;
        chk("fetch_ren", {31'b0, imemREN}, 32'd1);
        chk("fetch_addr", imemaddr, a);
        sb.push_back({a, mem_word(a)});
        tick();
        ihit = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [63:0] e;
        chk({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_empty: observed pop expected no entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc"}, instr_pc, e[63:32]);
            chk({tag, "_instr"}, instr, e[31:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; ihit = 1'b0; dstall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; halt_in = 1'b0; instr_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ren", {31'b0, imemREN}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_halt", {31'b0, halt}, 32'd0);
        chk("rst_addr", imemaddr, 32'h0);
        nRST = 1'b1;
        #1;
        chk("idle_ren", {31'b0, imemREN}, 32'd0);
        tick();

        // Sequential fill until the queue is full.
        for (int i = 0; i < 4; i++) fetch(32'(i * 4));
        #1;
        chk("full_count", {29'b0, count}, 32'd4);
        chk("full_ren", {31'b0, imemREN}, 32'd0);
        chk("full_valid", {31'b0, instr_valid}, 32'd1);
        chk("head_pc", instr_pc, sb[0][63:32]);
        tick();
        tick();
        chk("full_ren_hold", {31'b0, imemREN}, 32'd0);

        // One pop reopens space; push and pop together keep occupancy.
        instr_ready = 1'b1;
        #1;
        pop_check("pop1");
        tick();
        instr_ready = 1'b0;
        #1;
        chk("after_pop_count", {29'b0, count}, 32'd3);
        instr_ready = 1'b1;
        ihit = 1'b1;
        #1;
        chk("refill_ren", {31'b0, imemREN}, 32'd1);
        chk("refill_addr", imemaddr, 32'd16);
        pop_check("pushpop");
        sb.push_back({32'd16, mem_word(32'd16)});
        tick();
        ihit = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("pushpop_count", {29'b0, count}, 32'd3);
        fetch(32'd20);
        #1;
        chk("refull_count", {29'b0, count}, 32'd4);
        chk("refull_ren", {31'b0, imemREN}, 32'd0);

        // Redirect flushes; a hit in the redirect cycle is dropped.
        redirect = 1'b1;
        redirect_pc = 32'd8;
        #1;
        chk("redir_ren", {31'b0, imemREN}, 32'd0);
        tick();
        redirect = 1'b0;
        sb.delete();
        #1;
        chk("flush_count", {29'b0, count}, 32'd0);
        chk("flush_addr", imemaddr, 32'd8);
        tick();
        ihit = 1'b1;
        #1;
        chk("at8_ren", {31'b0, imemREN}, 32'd1);
        chk("at8_addr", imemaddr, 32'd8);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        #1;
        chk("redir_hit_ren", {31'b0, imemREN}, 32'd0);
        tick();
        redirect = 1'b0;
        ihit = 1'b0;
        #1;
        chk("drop_count", {29'b0, count}, 32'd0);
        chk("drop_valid", {31'b0, instr_valid}, 32'd0);
        chk("redir_addr", imemaddr, 32'h100);
        tick();
        fetch(32'h100);
        instr_ready = 1'b1;
        #1;
        pop_check("redir_head");
        tick();
        instr_ready = 1'b0;

        // Data stall during an outstanding request.
        dstall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ren", {31'b0, imemREN}, 32'd1);
            chk("stall_addr", imemaddr, 32'h104);
            tick();
        end
        fetch(32'h104);
        #1;
        chk("stall_count", {29'b0, count}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_idle_ren", {31'b0, imemREN}, 32'd0);
            tick();
        end
        dstall = 1'b0;
        #1;
        chk("unstall_ren0", {31'b0, imemREN}, 32'd0);
        tick();
        chk("unstall_ren1", {31'b0, imemREN}, 32'd1);
        chk("unstall_addr", imemaddr, 32'h108);
        instr_ready = 1'b1;
        #1;
        pop_check("stall_head");
        tick();
        instr_ready = 1'b0;

        // Halt together with redirect: halt wins and everything freezes.
        halt_in = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("halt_cyc_ren", {31'b0, imemREN}, 32'd0);
        tick();
        halt_in = 1'b0;
        redirect = 1'b0;
        #1;
        chk("halt_set", {31'b0, halt}, 32'd1);
        chk("halt_addr", imemaddr, 32'h108);
        for (int i = 0; i < 10; i++) begin
            ihit = 1'b1;
            instr_ready = 1'b1;
            redirect = i[0];
            redirect_pc = 32'h300;
            #1;
            chk("halted_ren", {31'b0, imemREN}, 32'd0);
            chk("halted_valid", {31'b0, instr_valid}, 32'd0);
            chk("halted_addr", imemaddr, 32'h108);
            chk("halted_halt", {31'b0, halt}, 32'd1);
            chk("halted_count", {29'b0, count}, 32'd0);
            tick();
        end
        ihit = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;

        // Reset clears halt; address wrap at the top of the space.
        nRST = 1'b0;
        #1;
        chk("rst2_halt", {31'b0, halt}, 32'd0);
        chk("rst2_addr", imemaddr, 32'h0);
        chk("rst2_ren", {31'b0, imemREN}, 32'd0);
        tick();
        nRST = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_redir_ren", {31'b0, imemREN}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("wrap_addr", imemaddr, 32'hFFFF_FFFC);
        tick();
        fetch(32'hFFFF_FFFC);
        fetch(32'h0);
        instr_ready = 1'b1;
        #1;
        chk("wrap_next_addr", imemaddr, 32'h4);
        pop_check("wrap_top");
        tick();
        pop_check("wrap_zero");
        tick();
        instr_ready = 1'b0;

        // Reset asserted in the middle of a request.
        ihit = 1'b1;
        #1;
        chk("mid_ren", {31'b0, imemREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_count", {29'b0, count}, 32'd0);
        chk("mid_rst_ren", {31'b0, imemREN}, 32'd0);
        chk("mid_rst_addr", imemaddr, 32'h0);
        tick();
        chk("mid_rst_count2", {29'b0, count}, 32'd0);
        ihit = 1'b0;
        nRST = 1'b1;
        #1;
        chk("post_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("post_rst_ren", {31'b0, imemREN}, 32'd0);
        tick();
        chk("post_rst_req", {31'b0, imemREN}, 32'd1);
        chk("post_rst_addr", imemaddr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
